// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART: FSM state encoding and frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_engine.sv
// Receive path: 2-flop synchroniser, mid-bit sampling FSM, shift register and
// the held output byte that only updates on a correctly framed character.
module uart_rx_engine #(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_line,
  output logic [DATA_BITS-1:0] rx_byte
);
  import uart_pkg::*;

  localparam int            CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

  logic                 sync1_r;
  logic                 sync2_r;
  uart_state_e          state_r;
  logic [CW-1:0]        cnt_r;
  logic [2:0]           idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] rx_byte_r;

  // Line synchroniser; resets to idle-high so an undriven line looks idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx_line;
      sync2_r <= sync1_r;
    end
  end

  // Receive FSM: the falling edge seen in IDLE is time zero; every later
  // sample lands HALF + n*CLKS_PER_BIT cycles after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      idx_r     <= 3'd0;
      shift_r   <= '0;
      rx_byte_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          idx_r <= 3'd0;
          if (sync2_r == START_BIT) begin
            // With one clock per bit the mid-point is the edge cycle itself.
            if (HALF == '0) begin
              state_r <= DATA;
            end else begin
              state_r <= START;
              cnt_r   <= CW'(1);
            end
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          if (cnt_r == HALF) begin
            cnt_r <= '0;
            if (sync2_r == START_BIT) begin
              state_r <= DATA;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DATA: begin
          if (cnt_r == LAST) begin
            cnt_r   <= '0;
            shift_r <= {sync2_r, shift_r[DATA_BITS-1:1]};
            if (idx_r == 3'd7) begin
              idx_r   <= 3'd0;
              state_r <= STOP;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        STOP: begin
          if (cnt_r == LAST) begin
            cnt_r   <= '0;
            state_r <= IDLE;
            // A low stop bit is a framing error: keep the previous byte.
            if (sync2_r == STOP_BIT) begin
              rx_byte_r <= shift_r;
            end else begin
              rx_byte_r <= rx_byte_r;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          idx_r   <= 3'd0;
        end
      endcase
    end
  end

  assign rx_byte = rx_byte_r;

endmodule

// File: rtl/uart_controller.sv
// Full-duplex 8N1 UART top: transmit FSM with a registered serial output and
// an instantiated receive engine, both timed by a fixed clocks-per-bit count.
module uart_controller #(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_ready,
  input  logic                 i_rx_data,
  output logic                 o_tx_data,
  output logic [DATA_BITS-1:0] o_rx_data
);
  import uart_pkg::*;

  localparam int            CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e          state_r;
  logic [CW-1:0]        cnt_r;
  logic [2:0]           idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 tx_r;

  // Transmit FSM; the line level for each bit is loaded on the edge that
  // enters that bit, so the start bit appears the cycle after acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      shift_r <= '0;
      tx_r    <= STOP_BIT;
    end else begin
      case (state_r)
        IDLE: begin
          tx_r  <= STOP_BIT;
          cnt_r <= '0;
          idx_r <= 3'd0;
          if (i_tx_ready) begin
            shift_r <= i_tx_data;
            tx_r    <= START_BIT;
            state_r <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          if (cnt_r == LAST) begin
            cnt_r   <= '0;
            state_r <= DATA;
            tx_r    <= shift_r[0];
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DATA: begin
          if (cnt_r == LAST) begin
            cnt_r <= '0;
            if (idx_r == 3'd7) begin
              idx_r   <= 3'd0;
              state_r <= STOP;
              tx_r    <= STOP_BIT;
            end else begin
              idx_r   <= idx_r + 3'd1;
              shift_r <= {1'b0, shift_r[DATA_BITS-1:1]};
              tx_r    <= shift_r[1];
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        STOP: begin
          if (cnt_r == LAST) begin
            cnt_r   <= '0;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          idx_r   <= 3'd0;
          tx_r    <= STOP_BIT;
        end
      endcase
    end
  end

  assign o_tx_data = tx_r;

  uart_rx_engine #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS)
  ) u_rx (
    .clk     (clk),
    .reset   (reset),
    .rx_line (i_rx_data),
    .rx_byte (o_rx_data)
  );

endmodule

// File: tb/tb_uart_controller.sv
// Self-checking bench: two UART instances (1 and 4 clocks per bit) driven by
// directed and random frames, checked against a frame-level reference model.
module tb_uart_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] txd1, txd4;
  logic       rdy1, rdy4;
  logic       rx1, rx4_drv, loop4;
  logic       rx4_line;
  logic       tx1, tx4;
  logic [7:0] rxb1, rxb4;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_rx1, exp_rx4;

  always #5 clk = ~clk;

  assign rx4_line = loop4 ? tx4 : rx4_drv;

  uart_controller #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(reset), .i_tx_data(txd1), .i_tx_ready(rdy1),
    .i_rx_data(rx1), .o_tx_data(tx1), .o_rx_data(rxb1)
  );

  uart_controller #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .reset(reset), .i_tx_data(txd4), .i_tx_ready(rdy4),
    .i_rx_data(rx4_line), .o_tx_data(tx4), .o_rx_data(rxb4)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expected);
    checks++;
    assert (obs === expected) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, expected);
    end
  endtask

  // Line level of frame bit j: start, eight data bits LSB first, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    else if (j <= 8) return b[j-1];
    else return 1'b1;
  endfunction

  // Request one TX frame and compare every line cycle; a pulse at step
  // pulse_at (1..10*cpb) lands mid-frame and must be ignored.
  task automatic tx_frame(input bit which, input logic [7:0] b, input int cpb, input int pulse_at);
    logic e;
    logic obs;
    @(negedge clk);
    if (which) begin rdy4 = 1'b1; txd4 = b; end
    else begin rdy1 = 1'b1; txd1 = b; end
    for (int s = 1; s <= 10*cpb + 1; s++) begin
      @(negedge clk);
      e   = (s - 1 < 10*cpb) ? frame_bit(b, (s - 1) / cpb) : 1'b1;
      obs = which ? tx4 : tx1;
      check($sformatf("tx_cpb%0d_%02h_step%0d", cpb, b, s), {7'd0, obs}, {7'd0, e});
      if (which) begin rdy4 = (s == pulse_at); txd4 = 8'($urandom); end
      else begin rdy1 = (s == pulse_at); txd1 = 8'($urandom); end
    end
    if (which) rdy4 = 1'b0; else rdy1 = 1'b0;
  endtask

  // Drive one RX frame; the byte must appear exactly 2 (sync) + cpb/2 +
  // 9*cpb cycles after the start bit is first sampled, not a cycle earlier.
  task automatic rx_frame(input bit which, input logic [7:0] b, input logic stop, input int cpb);
    int lat;
    logic [7:0] old_v, new_v, obs;
    logic line;
    lat   = 2 + cpb/2 + 9*cpb;
    old_v = which ? exp_rx4 : exp_rx1;
    new_v = stop ? b : old_v;
    for (int s = 0; s <= 10*cpb + 4; s++) begin
      @(negedge clk);
      obs = which ? rxb4 : rxb1;
      if (s == lat)     check($sformatf("rx_cpb%0d_%02h_before", cpb, b), obs, old_v);
      if (s == lat + 1) check($sformatf("rx_cpb%0d_%02h_after", cpb, b), obs, new_v);
      if (s < 10*cpb) line = (s / cpb == 9) ? stop : frame_bit(b, s / cpb);
      else line = 1'b1;
      if (which) rx4_drv = line; else rx1 = line;
    end
    if (which) exp_rx4 = new_v; else exp_rx1 = new_v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rb;
    reset = 1'b1; rdy1 = 1'b0; rdy4 = 1'b0; txd1 = 8'h00; txd4 = 8'h00;
    rx1 = 1'b1; rx4_drv = 1'b1; loop4 = 1'b0;
    exp_rx1 = 8'h00; exp_rx4 = 8'h00;

    // Reset and idle
    repeat (3) begin
      @(negedge clk);
      check("reset_tx1", {7'd0, tx1}, 8'h01);
      check("reset_rx1", rxb1, 8'h00);
    end
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("idle_tx1", {7'd0, tx1}, 8'h01);
      check("idle_rx1", rxb1, 8'h00);
      check("idle_tx4", {7'd0, tx4}, 8'h01);
      check("idle_rx4", rxb4, 8'h00);
    end

    // Directed frames
    tx_frame(1'b0, 8'h00, 1, 0);
    rx_frame(1'b0, 8'hF0, 1'b1, 1);
    tx_frame(1'b1, 8'hA5, 4, 13);
    rx_frame(1'b1, 8'h3C, 1'b1, 4);
    idle(6);
    rx_frame(1'b1, 8'hFF, 1'b0, 4);
    idle(8);
    check("framing_hold", rxb4, 8'h3C);

    // Random frames against the model
    for (int i = 0; i < 6; i++) begin
      tx_frame(1'b0, 8'($urandom), 1, $urandom_range(1, 10));
      tx_frame(1'b1, 8'($urandom), 4, $urandom_range(1, 40));
      rx_frame(1'b0, 8'($urandom), ($urandom_range(0, 3) != 0), 1);
      idle(6);
      rx_frame(1'b1, 8'($urandom), ($urandom_range(0, 3) != 0), 4);
      idle(8);
    end

    // Loopback
    loop4 = 1'b1;
    tx_frame(1'b1, 8'h5A, 4, 0);
    idle(3);
    check("loop_5a", rxb4, 8'h5A);

    // Reset in the middle of a looped-back frame
    @(negedge clk);
    rdy4 = 1'b1; txd4 = 8'h77;
    @(negedge clk);
    rdy4 = 1'b0;
    idle(20);
    reset = 1'b1;
    #1;
    check("midreset_tx4", {7'd0, tx4}, 8'h01);
    check("midreset_rx4", rxb4, 8'h00);
    check("midreset_rx1", rxb1, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    exp_rx1 = 8'h00; exp_rx4 = 8'h00;
    idle(50);
    check("postreset_rx4", rxb4, 8'h00);
    check("postreset_tx4", {7'd0, tx4}, 8'h01);
    tx_frame(1'b1, 8'hC3, 4, 0);
    idle(3);
    check("loop_c3", rxb4, 8'hC3);

    rb = 8'($urandom);
    tx_frame(1'b1, rb, 4, 0);
    idle(3);
    check("loop_rand", rxb4, rb);
    loop4 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
